// File: rtl/sampler_pkg.sv
// Shared types and helpers for the sampled-stream consumers: sequence type,
// classifier state encoding and a saturating adder for statistics counters.
package sampler_pkg;

  localparam int SEQ_W = 16;

  typedef logic [SEQ_W-1:0] seq_t;

  typedef enum logic [0:0] {
    ST_SYNC  = 1'b0,
    ST_TRACK = 1'b1
  } state_e;

  // Adds b to a and clamps at the all-ones value of a w-bit counter (w <= 64).
  // Callers narrow the result back to their own counter width.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << w) - 65'd1;
    return (sum > lim) ? lim[63:0] : sum[63:0];
  endfunction

endpackage

// File: rtl/sample_seq_checker_if.sv
// Sample stream bundle: upstream sample pulses in, buffered ready/valid stream out.
// Handshake: a word transfers downstream on any rising edge where valid_o && ready_i;
// valid_i is a single-cycle qualifier with no backpressure.
interface sample_seq_checker_if #(
  parameter int DATA_W = 64
) (
  input logic slow_clk
);

  logic [DATA_W-1:0] data_i;
  logic              valid_i;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              ready_i;

  modport master (
    input  slow_clk,
    output data_i,
    output valid_i,
    output ready_i,
    input  data_o,
    input  valid_o
  );

  modport slave (
    input  slow_clk,
    input  data_i,
    input  valid_i,
    input  ready_i,
    output data_o,
    output valid_o
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. The head word lives in a register so data_o is
// valid with no read latency and holds its last value once the FIFO drains.
module sync_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          data_i,
  output logic [DATA_W-1:0]          data_o,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q;
  logic [AW-1:0]     rd_q;
  logic [AW-1:0]     rd_next;
  logic [LW-1:0]     level_q;
  logic [LW-1:0]     level_d;
  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] head_d;
  logic              do_push;
  logic              do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign rd_next = rd_q + AW'(1);

  always_comb begin
    head_d  = head_q;
    level_d = level_q;
    if (do_push && (empty || (do_pop && level_q == LW'(1)))) begin
      head_d = data_i;
    end else if (do_pop && level_q > LW'(1)) begin
      head_d = mem_q[rd_next];
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      head_q  <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_next;
      level_q <= level_d;
      head_q  <= head_d;
    end
  end

  assign data_o = head_q;
  assign level  = level_q;

endmodule

// File: rtl/sample_seq_checker.sv
// Classifies sampled words by their embedded sequence number, keeps loss/dup
// statistics and buffers accepted words for in-order delivery downstream.
module sample_seq_checker
  import sampler_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int SEQ_W      = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32
) (
  input  logic                          slow_clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             data_i,
  input  logic                          valid_i,
  output logic [DATA_W-1:0]             data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [CNT_W-1:0]              captured_cnt,
  output logic [CNT_W-1:0]              missed_cnt,
  output logic [CNT_W-1:0]              dup_cnt,
  output logic [CNT_W-1:0]              ovf_cnt,
  output logic                          gap_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          state_o
);

  localparam logic [0:0] SYNC  = ST_SYNC;
  localparam logic [0:0] TRACK = ST_TRACK;

  logic [0:0]       state_q, state_d;
  logic [SEQ_W-1:0] expected_q, expected_d;
  logic [CNT_W-1:0] cap_q, cap_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic [CNT_W-1:0] dup_q, dup_d;
  logic [CNT_W-1:0] ovf_q, ovf_d;
  logic             gap_q, gap_d;

  logic [SEQ_W-1:0] seq;
  logic [SEQ_W-1:0] diff;
  logic             is_stale;
  logic             is_ahead;
  logic             accept;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;

  assign seq      = data_i[SEQ_W-1:0];
  // Modular distance; the top half of the range means the sample is behind.
  assign diff     = seq - expected_q;
  assign is_stale = diff[SEQ_W-1];
  assign is_ahead = !is_stale && (diff != '0);
  assign accept   = valid_i && ((state_q == SYNC) || !is_stale);

  assign fifo_push = accept;
  assign fifo_pop  = !fifo_empty && ready_i;

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    cap_d      = cap_q;
    miss_d     = miss_q;
    dup_d      = dup_q;
    ovf_d      = ovf_q;
    gap_d      = 1'b0;
    if (valid_i) begin
      if (accept) begin
        state_d    = TRACK;
        expected_d = seq + SEQ_W'(1);
        cap_d      = CNT_W'(sat_add(64'(cap_q), 64'd1, CNT_W));
        // Buffering is independent of classification: a full FIFO only drops the word.
        if (fifo_full && !fifo_pop) begin
          ovf_d = CNT_W'(sat_add(64'(ovf_q), 64'd1, CNT_W));
        end
        if ((state_q == TRACK) && is_ahead) begin
          miss_d = CNT_W'(sat_add(64'(miss_q), 64'(diff), CNT_W));
          gap_d  = 1'b1;
        end
      end else begin
        dup_d = CNT_W'(sat_add(64'(dup_q), 64'd1, CNT_W));
      end
    end
  end

  always_ff @(posedge slow_clk) begin
    if (rst) begin
      state_q    <= SYNC;
      expected_q <= '0;
      cap_q      <= '0;
      miss_q     <= '0;
      dup_q      <= '0;
      ovf_q      <= '0;
      gap_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      cap_q      <= cap_d;
      miss_q     <= miss_d;
      dup_q      <= dup_d;
      ovf_q      <= ovf_d;
      gap_q      <= gap_d;
    end
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk    (slow_clk),
    .rst    (rst),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .data_i (data_i),
    .data_o (data_o),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  assign valid_o      = !fifo_empty;
  assign captured_cnt = cap_q;
  assign missed_cnt   = miss_q;
  assign dup_cnt      = dup_q;
  assign ovf_cnt      = ovf_q;
  assign gap_o        = gap_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_sample_seq_checker.sv
// Directed bench for sample_seq_checker with a scoreboard on the output stream.
module tb_sample_seq_checker;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sample_seq_checker_if #(.DATA_W(DATA_W)) bus (.slow_clk(clk));

  logic [CNT_W-1:0]          captured_cnt, missed_cnt, dup_cnt, ovf_cnt;
  logic                      gap_o;
  logic [$clog2(DEPTH):0]    fifo_level;
  logic                      state_o;

  sample_seq_checker #(
    .DATA_W(DATA_W), .SEQ_W(16), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .slow_clk     (clk),
    .rst          (rst),
    .data_i       (bus.data_i),
    .valid_i      (bus.valid_i),
    .data_o       (bus.data_o),
    .valid_o      (bus.valid_o),
    .ready_i      (bus.ready_i),
    .captured_cnt (captured_cnt),
    .missed_cnt   (missed_cnt),
    .dup_cnt      (dup_cnt),
    .ovf_cnt      (ovf_cnt),
    .gap_o        (gap_o),
    .fifo_level   (fifo_level),
    .state_o      (state_o)
  );

  // scoreboard
  logic [DATA_W-1:0] exp_q[$];
  int                mdl_level = 0;
  int                total = 0;
  int                bad   = 0;
  logic [DATA_W-1:0] last_word;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: mid-cycle, a visible handshake means a pop at the next edge.
  always @(negedge clk) begin
    if (!rst && bus.valid_o && bus.ready_i) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        chk("sb_data", bus.data_o, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic model_edge(input bit want_push, input logic [DATA_W-1:0] w);
    bit pop;
    pop = bus.ready_i && (mdl_level > 0);
    if (want_push && (mdl_level < DEPTH || pop)) begin
      exp_q.push_back(w);
      mdl_level++;
    end
    if (pop) mdl_level--;
  endtask

  task automatic send(input logic [15:0] seq, input bit want_push);
    logic [DATA_W-1:0] w;
    w = {$urandom(), $urandom()};
    w[15:0] = seq;
    last_word = w;
    bus.data_i  = w;
    bus.valid_i = 1'b1;
    model_edge(want_push, w);
    tick();
    bus.valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      model_edge(1'b0, '0);
      tick();
    end
  endtask

  task automatic do_reset(input bit valid_during);
    rst = 1'b1;
    bus.valid_i = valid_during;
    bus.data_i  = 64'h0000_0000_0000_0004;
    tick();
    tick();
    rst = 1'b0;
    bus.valid_i = 1'b0;
    exp_q.delete();
    mdl_level = 0;
  endtask

  task automatic chk_cnts(input string tag, input int cap, input int miss,
                          input int dup, input int ovf);
    chk({tag, "_captured"}, 64'(captured_cnt), 64'(cap));
    chk({tag, "_missed"},   64'(missed_cnt),   64'(miss));
    chk({tag, "_dup"},      64'(dup_cnt),      64'(dup));
    chk({tag, "_ovf"},      64'(ovf_cnt),      64'(ovf));
  endtask

  initial begin
    bus.data_i  = '0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    last_word   = '0;

    // reset state
    do_reset(1'b0);
    chk("rst_valid_o", 64'(bus.valid_o), 64'd0);
    chk("rst_data_o", bus.data_o, 64'd0);
    chk("rst_gap", 64'(gap_o), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_state", 64'(state_o), 64'd0);
    chk_cnts("rst", 0, 0, 0, 0);

    // in-order 1..5, each word visible one cycle after input
    for (int s = 1; s <= 5; s++) begin
      send(16'(s), 1'b1);
      chk("inorder_data_o", bus.data_o, last_word);
      chk("inorder_valid_o", 64'(bus.valid_o), 64'd1);
    end
    chk("inorder_state", 64'(state_o), 64'd1);
    idle(2);
    chk_cnts("inorder", 5, 0, 0, 0);
    chk("inorder_drained", 64'(exp_q.size()), 64'd0);

    // gap: 1,2,5,6
    do_reset(1'b0);
    send(16'd1, 1'b1); chk("gap_pulse_1", 64'(gap_o), 64'd0);
    send(16'd2, 1'b1); chk("gap_pulse_2", 64'(gap_o), 64'd0);
    send(16'd5, 1'b1); chk("gap_pulse_5", 64'(gap_o), 64'd1);
    send(16'd6, 1'b1); chk("gap_pulse_6", 64'(gap_o), 64'd0);
    idle(2);
    chk_cnts("gap", 4, 2, 0, 0);

    // wraparound then duplicate
    do_reset(1'b0);
    send(16'hFFFE, 1'b1);
    send(16'hFFFF, 1'b1);
    send(16'h0000, 1'b1); chk("wrap_gap", 64'(gap_o), 64'd0);
    send(16'h0001, 1'b1);
    chk_cnts("wrap", 4, 0, 0, 0);
    send(16'h0001, 1'b0);
    chk("dup_gap", 64'(gap_o), 64'd0);
    idle(2);
    chk_cnts("dup", 4, 0, 1, 0);
    chk("dup_not_pushed", 64'(exp_q.size()), 64'd0);

    // overflow with ready low, then push+pop while full, then drain
    do_reset(1'b0);
    bus.ready_i = 1'b0;
    for (int s = 1; s <= 10; s++) send(16'(s), 1'b1);
    chk("ovf_level", 64'(fifo_level), 64'd8);
    chk_cnts("ovf", 10, 0, 0, 2);
    chk("ovf_head_valid", 64'(bus.valid_o), 64'd1);
    chk("ovf_head_data", 64'(bus.data_o[15:0]), 64'd1);
    bus.ready_i = 1'b1;
    send(16'd11, 1'b1);
    chk("full_pushpop_level", 64'(fifo_level), 64'd8);
    chk_cnts("full_pushpop", 11, 0, 0, 2);
    idle(10);
    chk("drain_level", 64'(fifo_level), 64'd0);
    chk("drain_valid_o", 64'(bus.valid_o), 64'd0);
    chk("drain_hold_data", bus.data_o, last_word);
    chk("drain_sb_empty", 64'(exp_q.size()), 64'd0);

    // mid-stream reset with a sample in the reset cycle
    do_reset(1'b0);
    send(16'd1, 1'b1);
    send(16'd2, 1'b1);
    bus.ready_i = 1'b0;
    send(16'd3, 1'b1);
    chk("pre_rst_level", 64'(fifo_level), 64'd2);
    do_reset(1'b1);
    chk_cnts("midrst", 0, 0, 0, 0);
    chk("midrst_valid_o", 64'(bus.valid_o), 64'd0);
    chk("midrst_level", 64'(fifo_level), 64'd0);
    chk("midrst_state", 64'(state_o), 64'd0);
    bus.ready_i = 1'b1;
    send(16'h0040, 1'b1);
    chk("post_rst_gap", 64'(gap_o), 64'd0);
    chk("post_rst_data", bus.data_o, last_word);
    chk_cnts("post_rst", 1, 0, 0, 0);
    idle(3);
    chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
